// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// offsets and claim-ID width.
package irq_ctrl_pkg;

  localparam int ID_W = 4;

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_ENABLE  = 4'h4;
  localparam logic [3:0] OFF_CLAIM   = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_sync.sv
// N-wide two-flop synchronizer bringing asynchronous interrupt lines into
// the clk_i domain.
module irq_sync #(
  parameter int N_IRQ = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_IRQ-1:0] async_i,
  output logic [N_IRQ-1:0] sync_o
);

  logic [N_IRQ-1:0] meta_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      meta_q <= '0;
      sync_o <= '0;
    end else begin
      meta_q <= async_i;
      sync_o <= meta_q;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: PENDING/ENABLE/CLAIM registers, fixed
// priority (index 0 highest), single-level REQ/SERVICE handshake with the CSR
// unit. Define IRQ_CTRL_EDGE_TRIG_EN for edge-latched pending; default is level.
//
// Handshake: meip_o is high exactly while state_o is REQ; an ack_i pulse seen
// in REQ takes the interrupt, and a CLAIM write of the matching ID completes it.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             ack_i,
  output logic             meip_o,
  input  logic [3:0]       addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             wen_i,
  output logic [31:0]      rdata_o,
  output logic [1:0]       state_o
);

  logic [N_IRQ-1:0] irq_sync_w;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] enable_q;
  logic [N_IRQ-1:0] pend_en;
  logic [ID_W-1:0]  claim_id_q;
  logic [ID_W-1:0]  prio_id;
  state_e           state_q;
  state_e           state_d;
  logic             wr_pending;
  logic             wr_enable;
  logic             wr_claim;
  logic             take;
  logic             complete;
  logic [31:0]      rd_val;
  logic             unused_sig;

  irq_sync #(.N_IRQ(N_IRQ)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (irq_i),
    .sync_o  (irq_sync_w)
  );

  assign wr_pending = !wen_i && (addr_i == OFF_PENDING);
  assign wr_enable  = !wen_i && (addr_i == OFF_ENABLE);
  assign wr_claim   = !wen_i && (addr_i == OFF_CLAIM);
  assign pend_en    = pending_q & enable_q;
  assign take       = (state_q == ST_REQ) && ack_i && (|pend_en);
  assign complete   = (state_q == ST_SERVICE) && wr_claim &&
                      (wdata_i[ID_W-1:0] == claim_id_q);
  assign unused_sig = ^{wdata_i, wr_pending};

  // Scan from the top so the lowest set index is the last one to win.
  always_comb begin
    prio_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_en[i]) prio_id = ID_W'(i);
    end
  end

`ifdef IRQ_CTRL_EDGE_TRIG_EN
  logic [N_IRQ-1:0] sync_prev_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] w1c_mask;
  logic [N_IRQ-1:0] claim_mask;

  assign rise       = irq_sync_w & ~sync_prev_q;
  assign w1c_mask   = wr_pending ? wdata_i[N_IRQ-1:0] : '0;
  assign claim_mask = take ? (N_IRQ'(1) << prio_id) : '0;

  // A fresh rising edge is OR'd in after the clears so it wins a same-cycle W1C.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_prev_q <= '0;
      pending_q   <= '0;
    end else begin
      sync_prev_q <= irq_sync_w;
      pending_q   <= (pending_q & ~(w1c_mask | claim_mask)) | rise;
    end
  end
`else
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= irq_sync_w;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_q   <= '0;
      claim_id_q <= '0;
    end else begin
      if (wr_enable) enable_q <= wdata_i[N_IRQ-1:0];
      if (take)      claim_id_q <= prio_id;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_en) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!(|pend_en))  state_d = ST_IDLE;
        else if (ack_i)   state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign meip_o  = (state_q == ST_REQ);
  assign state_o = state_q;

  always_comb begin
    rd_val = '0;
    case (addr_i)
      OFF_PENDING: rd_val[N_IRQ-1:0] = pending_q;
      OFF_ENABLE:  rd_val[N_IRQ-1:0] = enable_q;
      OFF_CLAIM: begin
        if (state_q == ST_SERVICE)
          rd_val[ID_W:0] = (ID_W+1)'(claim_id_q) + (ID_W+1)'(1);
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= rd_val;
    end
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8, number of external interrupt sources (legal 1..16).
REQ-002 clk_i  input  1  core clock; all state updates on rising edge.
REQ-003 reset_i  input  1  reset, asynchronous, active-low.
REQ-004 irq_i  input  N_IRQ  raw interrupt lines from peripherals, asynchronous to clk_i.
REQ-005 ack_i  input  1  interrupt-taken pulse from the CSR unit's ack output.
REQ-006 meip_o  output  1  machine external interrupt pending, to the CSR unit's meip input.
REQ-007 addr_i  input  4  byte offset of the memory-mapped register; only word offsets are used.
REQ-008 wdata_i  input  32  write data.
REQ-009 wen_i  input  1  write enable, active-low, matching core store convention.
REQ-010 rdata_o  output  32  registered read data for addr_i.

Function
REQ-011 Each irq_i bit SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Register map SHALL be: 0x0 PENDING (read; write-1-to-clear), 0x4 ENABLE (RW, bits N_IRQ-1:0), 0x8 CLAIM (read: in-service ID+1, 0 = none; write: complete). Other offsets read 0 and ignore writes.
REQ-013 Unused upper bits SHALL read 0.
REQ-014 FSM states SHALL be IDLE, REQ and SERVICE; reset state is IDLE.
REQ-015 IDLE -> REQ when (PENDING & ENABLE) != 0.
REQ-016 REQ -> SERVICE when ack_i = 1.
  - Claim ID latched = lowest-index set bit of PENDING & ENABLE (index 0 highest priority).
  - That PENDING bit is cleared in edge mode.
REQ-017 REQ -> IDLE when PENDING & ENABLE becomes 0 without ack_i (clear or disable).
REQ-018 SERVICE -> IDLE on a CLAIM write whose wdata_i[3:0] equals the latched ID; a mismatching write SHALL be ignored.
REQ-019 meip_o SHALL be 1 exactly while the state is REQ; it is 0 in IDLE and SERVICE (no nesting).
REQ-020 ack_i in IDLE or SERVICE SHALL be ignored.
REQ-021 Latency: irq_i rising before edge k with enable set SHALL give meip_o = 1 after edge k+3 (sync, sync, pending, state).
REQ-022 Set and clear in the same cycle: a new pending set SHALL win over a W1C clear of the same bit.
REQ-023 A new source pending during SERVICE SHALL stay latched and be presented (IDLE -> REQ) after completion.
REQ-024 rdata_o SHALL update one cycle after addr_i is presented, with the value before any same-cycle write.

Reset
REQ-025 Asserting reset_i SHALL immediately force:
  - state to IDLE;
  - PENDING, ENABLE, claim ID, synchronizers, meip_o and rdata_o to 0.
REQ-026 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the interrupt; no completion is required afterwards.

Configuration
REQ-027 Macro IRQ_CTRL_EDGE_TRIG_EN defined: PENDING bits set on a synchronized rising edge and stay set until W1C or claim.
REQ-028 Macro not defined (level mode):
  - PENDING bits equal the synchronized levels every cycle.
  - W1C writes and the claim-clear are ignored.
  - The source must drop its line before the handler completes.

Structure
REQ-029 Shared package irq_ctrl_pkg SHALL hold the FSM state encoding, the register offsets (0x0/0x4/0x8) and the ID width constant (4).
REQ-030 One sub-module irq_sync SHALL implement the N_IRQ-wide 2-flop synchronizer.
REQ-031 The priority encoder and the FSM SHALL remain in irq_ctrl.

Verification
REQ-032 Edge mode; ENABLE = 0x04; pulse irq_i[2] for 1 cycle -> meip_o = 1 after 3 edges; ack_i -> meip_o = 0, CLAIM reads 3, PENDING reads 0x00.
REQ-033 Edge mode; ENABLE = 0xFF; irq_i[5] and irq_i[1] rise together -> ack claims ID 1; write CLAIM = 1 -> REQ again; ack claims ID 5.
REQ-034 Edge mode; in REQ, write PENDING = 0x04 (only source) -> IDLE, meip_o = 0 without ack.
REQ-035 In SERVICE on ID 3, write CLAIM = 2 -> remains SERVICE; write CLAIM = 3 -> IDLE.
REQ-036 Level mode; hold irq_i[0] = 1; claim; write CLAIM = 0 with line still high -> meip_o reasserts within 2 cycles.
REQ-037 Assert reset_i = 0 while in SERVICE -> meip_o = 0 and all registers read 0 at once, with no clock edge needed.
